// File: rtl/sonic_sight_pkg.sv
// sonic_sight_pkg: shared frame width default and responder FSM state encoding
package sonic_sight_pkg;
    localparam int DATA_WIDTH_DEF = 16;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/spi_adc_responder_if.sv
// spi_adc_responder_if: sample staging inputs, SPI pins and event pulses of the ADC responder
interface spi_adc_responder_if import sonic_sight_pkg::*; #(parameter int DATA_WIDTH = DATA_WIDTH_DEF);
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  sample_valid_in;
    logic                  chip_clk_in;
    logic                  chip_sel_in;
    logic                  chip_data_out;
    logic                  frame_done_out;
    logic                  abort_out;
    logic                  underrun_out;
    logic                  drop_out;
    modport slave (
        input  sample_in, sample_valid_in, chip_clk_in, chip_sel_in,
        output chip_data_out, frame_done_out, abort_out, underrun_out, drop_out
    );
    modport master (
        output sample_in, sample_valid_in, chip_clk_in, chip_sel_in,
        input  chip_data_out, frame_done_out, abort_out, underrun_out, drop_out
    );
endinterface

// File: rtl/spi_adc_responder_sync_edge.sv
// sync_edge: 2-flop synchronizer plus one edge-detect register with rise/fall pulses
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] sync_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[1:0], d_i};
    end
    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/spi_adc_responder.sv
// spi_adc_responder: serves staged ADC samples MSB-first to an asynchronous SPI controller
module spi_adc_responder import sonic_sight_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    spi_adc_responder_if.slave   bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] stage_q, stage_d, shift_q, shift_d;
    logic                  full_q, full_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q, done_d, abort_q, abort_d, under_q, under_d, drop_q, drop_d;
    logic                  sclk_rise, sclk_fall, cs_rise, cs_fall, load;
    sync_edge u_sclk (.clk_i(clk_in), .rst_ni(rst_in), .d_i(bus.chip_clk_in), .rise_o(sclk_rise), .fall_o(sclk_fall));
    sync_edge u_cs   (.clk_i(clk_in), .rst_ni(rst_in), .d_i(bus.chip_sel_in), .rise_o(cs_rise),   .fall_o(cs_fall));
    assign load = (state_q == IDLE) & cs_fall;
    // A strobe coinciding with a frame load restages, so the stage stays full without a drop
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        stage_d  = bus.sample_valid_in ? bus.sample_in : stage_q;
        full_d   = bus.sample_valid_in | (full_q & ~load);
        drop_d   = bus.sample_valid_in & full_q & ~load;
        under_d  = load & ~full_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        unique case (state_q)
            IDLE: if (cs_fall) begin
                state_d = SHIFT;
                shift_d = stage_q;
                cnt_d   = '0;
            end
            SHIFT: if (cs_rise) begin
                abort_d = 1'b1;
                state_d = IDLE;
            end else begin
                if (sclk_rise) begin
                    cnt_d   = cnt_q + CW'(1);
                    done_d  = cnt_q == CW'(DATA_WIDTH - 1);
                    state_d = done_d ? DONE : SHIFT;
                end
                if (sclk_fall) shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
            end
            DONE: state_d = cs_rise ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            stage_q <= '0;
            shift_q <= '0;
            full_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            under_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            shift_q <= shift_d;
            full_q  <= full_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            under_q <= under_d;
            drop_q  <= drop_d;
        end
    end
    assign bus.chip_data_out  = (state_q == SHIFT) & shift_q[DATA_WIDTH-1];
    assign bus.frame_done_out = done_q;
    assign bus.abort_out      = abort_q;
    assign bus.underrun_out   = under_q;
    assign bus.drop_out       = drop_q;
endmodule

// File: tb/tb_spi_adc_responder.sv
// tb_spi_adc_responder: scoreboard bench driving staged samples and SPI frames into the responder
module tb_spi_adc_responder;
    localparam int DW = 16;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;
    spi_adc_responder_if #(.DATA_WIDTH(DW)) bus ();
    spi_adc_responder #(.DATA_WIDTH(DW)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));
    int n_chk = 0, n_fail = 0;
    int fd_n = 0, ab_n = 0, un_n = 0, dr_n = 0, dbl_n = 0;
    int e_fd = 0, e_ab = 0, e_un = 0, e_dr = 0;
    logic [DW-1:0] m_stage = '0;
    logic          m_full = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [3:0]    prev_p = '0;
    always @(negedge clk_in) begin
        logic [3:0] p;
        p = {bus.frame_done_out, bus.abort_out, bus.underrun_out, bus.drop_out};
        dbl_n += $countones(p & prev_p);
        prev_p = p;
        fd_n += int'(p[3]);
        ab_n += int'(p[2]);
        un_n += int'(p[1]);
        dr_n += int'(p[0]);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask
    task automatic chk_counts();
        chk("frame_done_cnt", fd_n, e_fd);
        chk("abort_cnt", ab_n, e_ab);
        chk("underrun_cnt", un_n, e_un);
        chk("drop_cnt", dr_n, e_dr);
    endtask
    task automatic stage(input logic [DW-1:0] v);
        if (m_full) e_dr++;
        m_stage = v;
        m_full  = 1'b1;
        bus.sample_in       = v;
        bus.sample_valid_in = 1'b1;
        tick(1);
        bus.sample_valid_in = 1'b0;
        tick(1);
    endtask
    task automatic sclk_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.chip_clk_in = 1'b1;
            tick(4);
            bus.chip_clk_in = 1'b0;
            tick(4);
        end
    endtask
    // nbits < DW ends the frame early; strobe puts sv on sample_in in the load cycle
    task automatic frame(input int nbits, input bit strobe, input logic [DW-1:0] sv);
        logic [DW-1:0] cap;
        cap = '0;
        if (!m_full) e_un++;
        if (nbits == DW) exp_q.push_back(m_stage);
        m_full = strobe;
        if (strobe) m_stage = sv;
        bus.chip_sel_in = 1'b0;
        if (strobe) begin
            tick(2);
            bus.sample_in       = sv;
            bus.sample_valid_in = 1'b1;
            tick(1);
            bus.sample_valid_in = 1'b0;
            tick(1);
        end else tick(4);
        for (int i = 0; i < nbits; i++) begin
            cap = {cap[DW-2:0], bus.chip_data_out};
            bus.chip_clk_in = 1'b1;
            tick(4);
            bus.chip_clk_in = 1'b0;
            tick(4);
        end
        if (nbits == DW) begin
            e_fd++;
            chk("frame_data", cap, exp_q.pop_front());
        end else e_ab++;
        bus.chip_sel_in = 1'b1;
        tick(6);
        chk("idle_data", bus.chip_data_out, 0);
        chk_counts();
    endtask
    initial begin
        bus.sample_in       = '0;
        bus.sample_valid_in = 1'b0;
        bus.chip_clk_in     = 1'b0;
        bus.chip_sel_in     = 1'b1;
        tick(3);
        chk("rst_data", bus.chip_data_out, 0);
        chk("rst_pulses", {bus.frame_done_out, bus.abort_out, bus.underrun_out, bus.drop_out}, 0);
        rst_in = 1'b1;
        tick(6);
        chk_counts();
        stage(16'hA5C3);
        frame(DW, 1'b0, '0);
        stage(16'h1111);
        stage(16'h2222);
        frame(DW, 1'b0, '0);
        stage(16'h00FF);
        frame(DW, 1'b0, '0);
        frame(DW, 1'b0, '0);
        stage(16'h5A5A);
        frame(7, 1'b0, '0);
        stage(16'h3C96);
        frame(DW, 1'b0, '0);
        stage(16'h1234);
        frame(DW, 1'b1, 16'hBEEF);
        frame(DW, 1'b0, '0);
        // reset in the middle of bit 9, released while CS is still low
        stage(16'h7E81);
        bus.chip_sel_in = 1'b0;
        tick(4);
        sclk_cycles(9);
        bus.chip_clk_in = 1'b1;
        tick(2);
        rst_in = 1'b0;
        tick(1);
        chk("mid_rst_data", bus.chip_data_out, 0);
        tick(2);
        bus.chip_clk_in = 1'b0;
        tick(2);
        rst_in = 1'b1;
        m_stage = '0;
        m_full  = 1'b0;
        tick(4);
        sclk_cycles(3);
        chk("post_rst_data", bus.chip_data_out, 0);
        chk_counts();
        bus.chip_sel_in = 1'b1;
        tick(6);
        chk_counts();
        frame(DW, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            stage(DW'($urandom));
            frame(DW, 1'b0, '0);
        end
        chk("no_double_pulse", dbl_n, 0);
        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_adc_responder.md
SPI_ADC_RESPONDER -- requirements
Module: spi_adc_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, bits per SPI frame; matches the ADC controller frame width.
REQ-002 Port clk_in  input  1  system clock (100 MHz); the only clock; all state on its rising edge.
REQ-003 Port rst_in  input  1  reset, asynchronous assert, active-low.
REQ-004 Port sample_in  input  DATA_WIDTH  next ADC sample to serve.
REQ-005 Port sample_valid_in  input  1  single-cycle strobe; sample_in is valid this cycle.
REQ-006 Port chip_clk_in  input  1  SPI SCLK from controller; idles low; asynchronous to clk_in.
REQ-007 Port chip_sel_in  input  1  SPI CS from controller; active-low; asynchronous to clk_in.
REQ-008 Port chip_data_out  output  1  SPI CIPO toward controller, MSB first.
REQ-009 Port frame_done_out  output  1  one-cycle pulse when DATA_WIDTH bits have been clocked out.
REQ-010 Port abort_out  output  1  one-cycle pulse when CS deasserts mid-frame.
REQ-011 Port underrun_out  output  1  one-cycle pulse when a frame starts with no fresh sample staged.
REQ-012 Port drop_out  output  1  one-cycle pulse when a staged, unsent sample is overwritten.

Function
REQ-013 chip_clk_in and chip_sel_in SHALL each pass a 2-flop synchronizer followed by one edge-detect register; all protocol decisions use the synchronized signals only.
REQ-014 Staging: on sample_valid_in, stage_reg <= sample_in and stage_full <= 1; if stage_full was already 1 and not consumed the same cycle, drop_out pulses.
REQ-015 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-016 IDLE -> SHIFT on synchronized CS falling edge: shift_reg <= stage_reg, bit_cnt <= 0, stage_full <= 0; if stage_full was 0, stage_reg is resent unchanged and underrun_out pulses.
REQ-017 Simultaneous load and sample_valid_in: shift_reg takes the old stage_reg, stage_reg takes sample_in, stage_full stays 1, no drop_out.
REQ-018 chip_data_out SHALL equal shift_reg MSB in SHIFT and SHALL be 0 in IDLE and DONE.
REQ-019 First MSB SHALL be driven no later than 4 clk_in cycles after the raw CS falling edge.
REQ-020 In SHIFT, each synchronized SCLK rising edge increments bit_cnt (width clog2(DATA_WIDTH+1)); each synchronized SCLK falling edge shifts shift_reg left by one, filling 0.
REQ-021 When bit_cnt reaches DATA_WIDTH: frame_done_out pulses once and the FSM goes to DONE; further SCLK edges are ignored.
REQ-022 DONE -> IDLE on synchronized CS rising edge, with no pulse.
REQ-023 SHIFT -> IDLE on synchronized CS rising edge before bit_cnt reaches DATA_WIDTH: abort_out pulses; the sample is discarded and not restaged.
REQ-024 SCLK high and low phases SHALL each be at least 4 clk_in cycles; shorter phases are out of scope and their behaviour is undefined.
REQ-025 All four pulse outputs SHALL be registered and never high for two consecutive cycles.

Reset
REQ-026 While rst_in is low: FSM in IDLE, synchronizers, stage_reg, shift_reg and bit_cnt cleared, stage_full 0, all outputs 0, asynchronously.
REQ-027 Reset asserted mid-frame SHALL abort silently (no abort_out); after release, the first valid frame needs a fresh CS falling edge.
REQ-028 A CS already low at reset release SHALL NOT start a frame.

Structure
REQ-029 The state enum and the DATA_WIDTH default SHALL live in the shared sonic_sight_pkg package.
REQ-030 One sub-module, sync_edge (2-flop synchronizer plus rise/fall pulse outputs, async active-low reset), SHALL be instantiated twice, for SCLK and CS.

Verification
REQ-031 Stage 0xA5C3, then CS low and 16 SCLK cycles (4-cycle phases) -> controller-side capture on SCLK rising edges reads 0xA5C3; frame_done_out pulses once; no other pulses.
REQ-032 Two strobes (0x1111, then 0x2222) before a frame -> drop_out pulses on the second strobe; frame returns 0x2222.
REQ-033 Frame with nothing staged after a frame that sent 0x00FF -> underrun_out pulses; frame returns 0x00FF.
REQ-034 CS deasserted after 7 SCLK edges -> abort_out pulses; chip_data_out returns to 0; the next staged sample is sent intact in the next full frame.
REQ-035 sample_valid_in with 0xBEEF in the same cycle as the synchronized CS fall, old stage 0x1234 -> frame returns 0x1234; stage_reg holds 0xBEEF; stage_full 1; no drop_out.
REQ-036 rst_in low during bit 9, then released with CS still low -> no frame starts and no pulses occur until CS rises and falls again.
